// File: rtl/ddr3_mon_pkg.sv
// Shared types and command decode for the passive DDR3 bank monitor.
package ddr3_mon_pkg;

  // Decoded command on one ck edge.
  typedef enum logic [4:0] {
    CMD_NOP,
    CMD_DES,
    CMD_MRS,
    CMD_REF,
    CMD_SRE,
    CMD_SRX,
    CMD_PRE,
    CMD_PREA,
    CMD_ACT,
    CMD_WR,
    CMD_WRAP,
    CMD_RD,
    CMD_RDAP,
    CMD_PDE,
    CMD_PDX,
    CMD_ZQCL,
    CMD_ZQCS,
    CMD_UNK
  } cmd_t;

  // Violation codes; a lower code has higher priority.
  typedef enum logic [3:0] {
    ERR_NONE,
    ERR_RFC,
    ERR_MRD,
    ERR_ACT,
    ERR_RCD,
    ERR_CLOSED,
    ERR_RAS,
    ERR_REF,
    ERR_UNK
  } err_t;

  // Per-bank row state.
  typedef enum logic [1:0] {
    BANK_IDLE,
    BANK_ACTIVATING,
    BANK_ACTIVE,
    BANK_PRECHARGING
  } bank_state_t;

  // Command truth table. A12 (burst chop) does not change the command class,
  // so it is not an input here. SRX and PDX share a pin pattern and are told
  // apart by whether self-refresh was entered earlier.
  function automatic cmd_t decode_cmd(
    input logic prev_cke,
    input logic cke,
    input logic cs_n,
    input logic ras_n,
    input logic cas_n,
    input logic we_n,
    input logic a10,
    input logic in_sr
  );
    cmd_t       c;
    logic [2:0] rcw;
    rcw = {ras_n, cas_n, we_n};
    c   = CMD_UNK;
    case ({prev_cke, cke})
      2'b11: begin
        if (cs_n) begin
          c = CMD_DES;
        end else begin
          case (rcw)
            3'b000:  c = CMD_MRS;
            3'b001:  c = CMD_REF;
            3'b010:  c = a10 ? CMD_PREA : CMD_PRE;
            3'b011:  c = CMD_ACT;
            3'b100:  c = a10 ? CMD_WRAP : CMD_WR;
            3'b101:  c = a10 ? CMD_RDAP : CMD_RD;
            3'b110:  c = a10 ? CMD_ZQCL : CMD_ZQCS;
            default: c = CMD_NOP;
          endcase
        end
      end
      2'b10: begin
        if (!cs_n && rcw == 3'b001)       c = CMD_SRE;
        else if (cs_n || rcw == 3'b111)   c = CMD_PDE;
        else                              c = CMD_UNK;
      end
      2'b01: begin
        if (cs_n || rcw == 3'b111)        c = in_sr ? CMD_SRX : CMD_PDX;
        else                              c = CMD_UNK;
      end
      default: c = CMD_NOP;  // cke held low: bus is ignored by the DRAM
    endcase
    return c;
  endfunction

  // Anything other than NOP/DES counts as a real command.
  function automatic logic is_valid_cmd(input cmd_t c);
    return (c != CMD_NOP) && (c != CMD_DES);
  endfunction

  // Column accesses, with or without auto-precharge.
  function automatic logic is_rw_cmd(input cmd_t c);
    return (c == CMD_RD) || (c == CMD_RDAP) || (c == CMD_WR) || (c == CMD_WRAP);
  endfunction

endpackage

// File: rtl/ddr3_bank_fsm.sv
// One DRAM bank: row state, latched row and the tRCD/tRP/tRAS counters.
// All checks use the post-expiry view of the bank so that a command landing
// on the same edge a counter runs out is judged against the settled state.
module ddr3_bank_fsm
  import ddr3_mon_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int T_RCD     = 5,
  parameter int T_RP      = 5,
  parameter int T_RAS     = 15,
  parameter int CNT_W     = 8
) (
  input  logic                 ck,
  input  logic                 rst,
  input  cmd_t                 cmd,
  input  logic                 hit,
  input  logic [ADDR_BITS-1:0] row_in,
  output bank_state_t          state,
  output logic                 open,
  output logic [ADDR_BITS-1:0] row,
  output logic                 act_err,
  output logic                 rcd_err,
  output logic                 closed_err,
  output logic                 ras_err
);

  bank_state_t          state_reg;
  bank_state_t          state_eff;
  logic [CNT_W-1:0]     rcd_cnt_reg;
  logic [CNT_W-1:0]     rp_cnt_reg;
  logic [CNT_W-1:0]     ras_cnt_reg;
  logic [CNT_W-1:0]     rcd_dec;
  logic [CNT_W-1:0]     rp_dec;
  logic [CNT_W-1:0]     ras_dec;
  logic [ADDR_BITS-1:0] row_reg;
  logic                 pre_hit;
  logic                 close_now;

  // Saturating decrements: the value each counter takes on this edge.
  assign rcd_dec = (rcd_cnt_reg == '0) ? '0 : rcd_cnt_reg - CNT_W'(1);
  assign rp_dec  = (rp_cnt_reg  == '0) ? '0 : rp_cnt_reg  - CNT_W'(1);
  assign ras_dec = (ras_cnt_reg == '0) ? '0 : ras_cnt_reg - CNT_W'(1);

  // Bank state after any counter expiring on this edge.
  always_comb begin
    state_eff = state_reg;
    if (state_reg == BANK_ACTIVATING && rcd_dec == '0)  state_eff = BANK_ACTIVE;
    if (state_reg == BANK_PRECHARGING && rp_dec == '0)  state_eff = BANK_IDLE;
  end

  assign open    = (state_eff == BANK_ACTIVATING) || (state_eff == BANK_ACTIVE);
  assign pre_hit = (cmd == CMD_PRE && hit) || (cmd == CMD_PREA);

  // Explicit precharge closes any open row; auto-precharge only from ACTIVE.
  assign close_now = (pre_hit && open) ||
                     (((cmd == CMD_RDAP) || (cmd == CMD_WRAP)) && hit &&
                      state_eff == BANK_ACTIVE);

  assign act_err    = (cmd == CMD_ACT) && hit && (state_eff != BANK_IDLE);
  assign rcd_err    = is_rw_cmd(cmd) && hit && (state_eff == BANK_ACTIVATING);
  assign closed_err = is_rw_cmd(cmd) && hit &&
                      ((state_eff == BANK_IDLE) || (state_eff == BANK_PRECHARGING));
  assign ras_err    = pre_hit && open && (ras_dec != '0);

  // Bank state, counters and row; violating commands still take effect.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_reg   <= BANK_IDLE;
      rcd_cnt_reg <= '0;
      rp_cnt_reg  <= '0;
      ras_cnt_reg <= '0;
      row_reg     <= '0;
    end else begin
      state_reg   <= state_eff;
      rcd_cnt_reg <= rcd_dec;
      rp_cnt_reg  <= rp_dec;
      ras_cnt_reg <= ras_dec;
      if (cmd == CMD_ACT && hit) begin
        state_reg   <= BANK_ACTIVATING;
        rcd_cnt_reg <= CNT_W'(T_RCD);
        ras_cnt_reg <= CNT_W'(T_RAS);
        row_reg     <= row_in;
      end else if (close_now) begin
        state_reg  <= BANK_PRECHARGING;
        rp_cnt_reg <= CNT_W'(T_RP);
      end
    end
  end

  assign state = state_reg;
  assign row   = row_reg;

endmodule

// File: rtl/ddr3_bank_monitor.sv
// Passive DDR3 command-bus monitor: decodes commands, tracks every bank and
// reports the highest-priority timing/protocol violation each cycle.
module ddr3_bank_monitor
  import ddr3_mon_pkg::*;
#(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 16,
  parameter int T_RCD     = 5,
  parameter int T_RP      = 5,
  parameter int T_RAS     = 15,
  parameter int T_RFC     = 44,
  parameter int T_MRD     = 4,
  parameter int CNT_W     = 8
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic                    cke,
  input  logic                    cs_n,
  input  logic                    ras_n,
  input  logic                    cas_n,
  input  logic                    we_n,
  input  logic [BA_BITS-1:0]      ba,
  input  logic [ADDR_BITS-1:0]    addr,
  output cmd_t                    cmd,
  output logic                    cmd_valid,
  output logic [(2**BA_BITS)-1:0] bank_open,
  output logic [ADDR_BITS-1:0]    open_row,
  input  logic [BA_BITS-1:0]      query_ba,
  output logic                    err_valid,
  output err_t                    err_code,
  output logic [BA_BITS-1:0]      err_bank
);

  localparam int NUM_BANKS = 2**BA_BITS;

  logic                 prev_cke_reg;
  logic                 in_sr_reg;
  logic [CNT_W-1:0]     rfc_cnt_reg;
  logic [CNT_W-1:0]     mrd_cnt_reg;
  logic [CNT_W-1:0]     rfc_dec;
  logic [CNT_W-1:0]     mrd_dec;
  cmd_t                 cmd_reg;
  logic                 cmd_valid_reg;
  logic                 err_valid_reg;
  err_t                 err_code_reg;
  logic [BA_BITS-1:0]   err_bank_reg;
  err_t                 err_code_next;
  logic [BA_BITS-1:0]   err_bank_next;

  cmd_t                 cmd_now;
  logic                 valid_now;
  logic [NUM_BANKS-1:0] act_vec;
  logic [NUM_BANKS-1:0] rcd_vec;
  logic [NUM_BANKS-1:0] closed_vec;
  logic [NUM_BANKS-1:0] ras_vec;
  logic [NUM_BANKS-1:0] open_vec;
  bank_state_t          st_arr  [NUM_BANKS];
  logic [ADDR_BITS-1:0] row_arr [NUM_BANKS];

  // Lowest set index, used to pick the reported bank for multi-bank errors.
  function automatic logic [BA_BITS-1:0] lowest_set(input logic [NUM_BANKS-1:0] v);
    logic [BA_BITS-1:0] idx;
    idx = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (v[i]) idx = BA_BITS'(i);
    end
    return idx;
  endfunction

  assign cmd_now   = decode_cmd(prev_cke_reg, cke, cs_n, ras_n, cas_n, we_n,
                                addr[10], in_sr_reg);
  assign valid_now = is_valid_cmd(cmd_now);

  assign rfc_dec = (rfc_cnt_reg == '0) ? '0 : rfc_cnt_reg - CNT_W'(1);
  assign mrd_dec = (mrd_cnt_reg == '0) ? '0 : mrd_cnt_reg - CNT_W'(1);

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      ddr3_bank_fsm #(
        .ADDR_BITS (ADDR_BITS),
        .T_RCD     (T_RCD),
        .T_RP      (T_RP),
        .T_RAS     (T_RAS),
        .CNT_W     (CNT_W)
      ) u_bank (
        .ck         (ck),
        .rst        (rst),
        .cmd        (cmd_now),
        .hit        (ba == BA_BITS'(gi)),
        .row_in     (addr),
        .state      (st_arr[gi]),
        .open       (open_vec[gi]),
        .row        (row_arr[gi]),
        .act_err    (act_vec[gi]),
        .rcd_err    (rcd_vec[gi]),
        .closed_err (closed_vec[gi]),
        .ras_err    (ras_vec[gi])
      );
      assign bank_open[gi] = (st_arr[gi] == BANK_ACTIVATING) ||
                             (st_arr[gi] == BANK_ACTIVE);
    end
  endgenerate

  assign open_row = row_arr[query_ba];

  // Error priority encoder: the lowest code present this edge wins.
  always_comb begin
    err_code_next = ERR_NONE;
    err_bank_next = ba;
    if (valid_now && rfc_dec != '0) begin
      err_code_next = ERR_RFC;
    end else if (valid_now && mrd_dec != '0) begin
      err_code_next = ERR_MRD;
    end else if (|act_vec) begin
      err_code_next = ERR_ACT;
      err_bank_next = lowest_set(act_vec);
    end else if (|rcd_vec) begin
      err_code_next = ERR_RCD;
      err_bank_next = lowest_set(rcd_vec);
    end else if (|closed_vec) begin
      err_code_next = ERR_CLOSED;
      err_bank_next = lowest_set(closed_vec);
    end else if (|ras_vec) begin
      err_code_next = ERR_RAS;
      err_bank_next = lowest_set(ras_vec);
    end else if (cmd_now == CMD_REF && |open_vec) begin
      err_code_next = ERR_REF;
      err_bank_next = lowest_set(open_vec);
    end else if (cmd_now == CMD_UNK) begin
      err_code_next = ERR_UNK;
    end
  end

  // Decode register, global tRFC/tMRD counters, self-refresh tracking and error outputs.
  always_ff @(posedge ck) begin
    if (rst) begin
      prev_cke_reg  <= 1'b1;
      in_sr_reg     <= 1'b0;
      rfc_cnt_reg   <= '0;
      mrd_cnt_reg   <= '0;
      cmd_reg       <= CMD_NOP;
      cmd_valid_reg <= 1'b0;
      err_valid_reg <= 1'b0;
      err_code_reg  <= ERR_NONE;
      err_bank_reg  <= '0;
    end else begin
      prev_cke_reg <= cke;
      if (cmd_now == CMD_SRE)      in_sr_reg <= 1'b1;
      else if (cmd_now == CMD_SRX) in_sr_reg <= 1'b0;
      rfc_cnt_reg   <= (cmd_now == CMD_REF) ? CNT_W'(T_RFC) : rfc_dec;
      mrd_cnt_reg   <= (cmd_now == CMD_MRS) ? CNT_W'(T_MRD) : mrd_dec;
      cmd_reg       <= cmd_now;
      cmd_valid_reg <= valid_now;
      err_valid_reg <= (err_code_next != ERR_NONE);
      err_code_reg  <= err_code_next;
      err_bank_reg  <= err_bank_next;
    end
  end

  assign cmd       = cmd_reg;
  assign cmd_valid = cmd_valid_reg;
  assign err_valid = err_valid_reg;
  assign err_code  = err_code_reg;
  assign err_bank  = err_bank_reg;

endmodule

// File: tb/tb_ddr3_bank_monitor.sv
// Directed bench for ddr3_bank_monitor with a scoreboard of expected
// command/error results, one line printed per transaction.
module tb_ddr3_bank_monitor;
  import ddr3_mon_pkg::*;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        cke = 1'b1;
  logic        cs_n = 1'b0;
  logic        ras_n = 1'b1;
  logic        cas_n = 1'b1;
  logic        we_n = 1'b1;
  logic [2:0]  ba = '0;
  logic [15:0] addr = '0;
  logic [2:0]  query_ba = '0;
  cmd_t        cmd;
  logic        cmd_valid;
  logic [7:0]  bank_open;
  logic [15:0] open_row;
  logic        err_valid;
  err_t        err_code;
  logic [2:0]  err_bank;

  int checks = 0;
  int failures = 0;

  typedef struct {
    cmd_t       cmd;
    err_t       code;
    logic [2:0] bank;
  } exp_t;
  exp_t sb[$];

  always #5 ck = ~ck;

  ddr3_bank_monitor dut (
    .ck        (ck),
    .rst       (rst),
    .cke       (cke),
    .cs_n      (cs_n),
    .ras_n     (ras_n),
    .cas_n     (cas_n),
    .we_n      (we_n),
    .ba        (ba),
    .addr      (addr),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .bank_open (bank_open),
    .open_row  (open_row),
    .query_ba  (query_ba),
    .err_valid (err_valid),
    .err_code  (err_code),
    .err_bank  (err_bank)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Put a command on the pins following the DDR3 truth table.
  task automatic drive_pins(input cmd_t c, input logic [2:0] b, input logic [15:0] a,
                            input logic ck_en);
    cke  = ck_en;
    ba   = b;
    addr = a;
    cs_n = 1'b0;
    case (c)
      CMD_DES:  begin cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111; end
      CMD_MRS:  {ras_n, cas_n, we_n} = 3'b000;
      CMD_REF:  {ras_n, cas_n, we_n} = 3'b001;
      CMD_PRE:  begin {ras_n, cas_n, we_n} = 3'b010; addr[10] = 1'b0; end
      CMD_PREA: begin {ras_n, cas_n, we_n} = 3'b010; addr[10] = 1'b1; end
      CMD_ACT:  {ras_n, cas_n, we_n} = 3'b011;
      CMD_WR:   begin {ras_n, cas_n, we_n} = 3'b100; addr[10] = 1'b0; end
      CMD_WRAP: begin {ras_n, cas_n, we_n} = 3'b100; addr[10] = 1'b1; end
      CMD_RD:   begin {ras_n, cas_n, we_n} = 3'b101; addr[10] = 1'b0; end
      CMD_RDAP: begin {ras_n, cas_n, we_n} = 3'b101; addr[10] = 1'b1; end
      default:  {ras_n, cas_n, we_n} = 3'b111;
    endcase
  endtask

  // One command cycle: drive on negedge, push expectation, pop and compare after the edge.
  task automatic issue(input string tag, input cmd_t c, input logic [2:0] b,
                       input logic [15:0] a, input logic ck_en, input cmd_t exp_cmd,
                       input err_t exp_code, input logic [2:0] exp_bank);
    exp_t e;
    @(negedge ck);
    drive_pins(c, b, a, ck_en);
    e.cmd  = exp_cmd;
    e.code = exp_code;
    e.bank = exp_bank;
    sb.push_back(e);
    @(posedge ck);
    #1;
    e = sb.pop_front();
    $display("txn %s: cmd=%s err_valid=%0d err_code=%s err_bank=%0d bank_open=0x%02h",
             tag, cmd.name(), err_valid, err_code.name(), err_bank, bank_open);
    check({tag, " cmd"}, 32'(cmd), 32'(e.cmd));
    check({tag, " cmd_valid"}, 32'(cmd_valid),
          32'((e.cmd != CMD_NOP) && (e.cmd != CMD_DES)));
    check({tag, " err_valid"}, 32'(err_valid), 32'(e.code != ERR_NONE));
    check({tag, " err_code"}, 32'(err_code), 32'(e.code));
    if (e.code != ERR_NONE) check({tag, " err_bank"}, 32'(err_bank), 32'(e.bank));
  endtask

  task automatic nops(input string tag, input int n);
    for (int i = 0; i < n; i++) issue(tag, CMD_NOP, 3'd0, 16'h0, 1'b1, CMD_NOP, ERR_NONE, 3'd0);
  endtask

  // One reset cycle, then check every output returns to its reset value.
  task automatic do_reset(input string tag);
    @(negedge ck);
    rst = 1'b1;
    drive_pins(CMD_NOP, 3'd0, 16'h0, 1'b1);
    @(posedge ck);
    #1;
    $display("txn %s: reset cmd=%s bank_open=0x%02h err_valid=%0d", tag, cmd.name(),
             bank_open, err_valid);
    check({tag, " rst cmd"}, 32'(cmd), 32'(CMD_NOP));
    check({tag, " rst cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, " rst bank_open"}, 32'(bank_open), 32'd0);
    check({tag, " rst err_valid"}, 32'(err_valid), 32'd0);
    check({tag, " rst err_code"}, 32'(err_code), 32'(ERR_NONE));
    check({tag, " rst open_row"}, 32'(open_row), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    // Basic ACT then RD exactly tRCD later.
    do_reset("t1");
    issue("t1 act", CMD_ACT, 3'd2, 16'h01A3, 1'b1, CMD_ACT, ERR_NONE, 3'd0);
    nops("t1 wait", 4);
    issue("t1 rd", CMD_RD, 3'd2, 16'h0000, 1'b1, CMD_RD, ERR_NONE, 3'd0);
    check("t1 bank_open", 32'(bank_open), 32'h04);
    query_ba = 3'd2;
    #1;
    check("t1 open_row", 32'(open_row), 32'h01A3);

    // RD three cycles after ACT violates tRCD; the pulse lasts one cycle.
    do_reset("t2");
    issue("t2 act", CMD_ACT, 3'd0, 16'h0042, 1'b1, CMD_ACT, ERR_NONE, 3'd0);
    nops("t2 wait", 2);
    issue("t2 rd", CMD_RD, 3'd0, 16'h0000, 1'b1, CMD_RD, ERR_RCD, 3'd0);
    nops("t2 after", 1);

    // Early PRE violates tRAS, then ACT into the precharging bank.
    do_reset("t3");
    issue("t3 act", CMD_ACT, 3'd1, 16'h0777, 1'b1, CMD_ACT, ERR_NONE, 3'd0);
    nops("t3 wait", 9);
    issue("t3 pre", CMD_PRE, 3'd1, 16'h0000, 1'b1, CMD_PRE, ERR_RAS, 3'd1);
    nops("t3 gap", 1);
    issue("t3 act2", CMD_ACT, 3'd1, 16'h0777, 1'b1, CMD_ACT, ERR_ACT, 3'd1);

    // tRFC: commands inside the window are flagged but still take effect,
    // so bank 3 is closed again before the ACT at the window boundary.
    do_reset("t4");
    issue("t4 ref", CMD_REF, 3'd0, 16'h0000, 1'b1, CMD_REF, ERR_NONE, 3'd0);
    nops("t4 wait", 19);
    issue("t4 act20", CMD_ACT, 3'd3, 16'h0123, 1'b1, CMD_ACT, ERR_RFC, 3'd3);
    nops("t4 wait2", 14);
    issue("t4 pre35", CMD_PRE, 3'd3, 16'h0000, 1'b1, CMD_PRE, ERR_RFC, 3'd3);
    nops("t4 wait3", 8);
    issue("t4 act44", CMD_ACT, 3'd3, 16'h0123, 1'b1, CMD_ACT, ERR_NONE, 3'd0);

    // Two open banks, PREA at the tRAS boundary of the later one, then REF.
    do_reset("t5");
    issue("t5 act0", CMD_ACT, 3'd0, 16'h0011, 1'b1, CMD_ACT, ERR_NONE, 3'd0);
    issue("t5 act5", CMD_ACT, 3'd5, 16'h0055, 1'b1, CMD_ACT, ERR_NONE, 3'd0);
    check("t5 bank_open", 32'(bank_open), 32'h21);
    query_ba = 3'd5;
    #1;
    check("t5 open_row", 32'(open_row), 32'h0055);
    nops("t5 wait", 14);
    issue("t5 prea", CMD_PREA, 3'd0, 16'h0000, 1'b1, CMD_PREA, ERR_NONE, 3'd0);
    check("t5 closed", 32'(bank_open), 32'h00);
    nops("t5 rp", 4);
    issue("t5 ref", CMD_REF, 3'd0, 16'h0000, 1'b1, CMD_REF, ERR_NONE, 3'd0);
    check("t5 bank_open after", 32'(bank_open), 32'h00);

    // Reset mid-operation closes the bank; RD then hits a closed bank.
    do_reset("t6");
    issue("t6 act", CMD_ACT, 3'd4, 16'h0444, 1'b1, CMD_ACT, ERR_NONE, 3'd0);
    nops("t6 wait", 2);
    check("t6 bank_open", 32'(bank_open), 32'h10);
    do_reset("t6");
    issue("t6 rd", CMD_RD, 3'd4, 16'h0000, 1'b1, CMD_RD, ERR_CLOSED, 3'd4);

    // tMRD: inside the window is an error, at the boundary it is not.
    do_reset("t7");
    issue("t7 mrs", CMD_MRS, 3'd0, 16'h0000, 1'b1, CMD_MRS, ERR_NONE, 3'd0);
    nops("t7 wait", 1);
    issue("t7 act2", CMD_ACT, 3'd6, 16'h0066, 1'b1, CMD_ACT, ERR_MRD, 3'd6);
    nops("t7 wait2", 1);
    issue("t7 act4", CMD_ACT, 3'd7, 16'h0077, 1'b1, CMD_ACT, ERR_NONE, 3'd0);

    // ACT pattern while cke falls is undefined; the following cke rise is PDX.
    do_reset("t8");
    issue("t8 unk", CMD_ACT, 3'd6, 16'h0000, 1'b0, CMD_UNK, ERR_UNK, 3'd6);
    issue("t8 pdx", CMD_NOP, 3'd0, 16'h0000, 1'b1, CMD_PDX, ERR_NONE, 3'd0);
    nops("t8 after", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
